// File: rtl/instr_fetch_mem_if.sv
// Fetch request/response, flush and program-load signals between a fetch client (master) and the instruction memory (slave).
// The response fields are registered in the memory. req_ready is combinational from the memory state.
interface instr_fetch_mem_if #(
    parameter int FETCH_W = 2,
    parameter int ADDR_W  = 64
);
    logic                   req_valid;
    logic                   req_ready;
    logic [ADDR_W-1:0]      req_pc;
    logic                   flush;
    logic                   resp_valid;
    logic                   resp_ready;
    logic [ADDR_W-1:0]      resp_pc;
    logic [32*FETCH_W-1:0]  resp_instr;
    logic [FETCH_W-1:0]     resp_mask;
    logic                   resp_err;
    logic                   ld_en;
    logic [ADDR_W-1:0]      ld_addr;
    logic [31:0]            ld_data;

    modport master (
        output req_valid, req_pc, flush, resp_ready, ld_en, ld_addr, ld_data,
        input  req_ready, resp_valid, resp_pc, resp_instr, resp_mask, resp_err
    );

    modport slave (
        input  req_valid, req_pc, flush, resp_ready, ld_en, ld_addr, ld_data,
        output req_ready, resp_valid, resp_pc, resp_instr, resp_mask, resp_err
    );
endinterface

// File: rtl/instr_fetch_mem.sv
// Instruction memory returning FETCH_W words per request with a 1-cycle registered response; a stalled response holds req_ready low.
// Defining the macro IMEM_MISALIGN_CHK_EN turns on misaligned-PC detection through resp_err.
module instr_fetch_mem #(
    parameter int FETCH_W     = 2,
    parameter int DEPTH_WORDS = 16384,
    parameter int ADDR_W      = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    instr_fetch_mem_if.slave   bus
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);

    logic [31:0]            mem [DEPTH_WORDS];

    logic                   resp_valid_q;
    logic [ADDR_W-1:0]      resp_pc_q;
    logic [32*FETCH_W-1:0]  resp_instr_q;
    logic [FETCH_W-1:0]     resp_mask_q;
    logic                   resp_err_q;

    logic                   req_ready;
    logic                   accept;
    logic                   misalign;
    logic                   ld_in_range;
    logic [ADDR_W-2:0]      base;
    logic [32*FETCH_W-1:0]  rd_instr;
    logic [FETCH_W-1:0]     rd_mask;
    logic                   unused_addr_lo;

    assign req_ready = !bus.ld_en && !bus.flush && (!resp_valid_q || bus.resp_ready);
    assign accept    = bus.req_valid && req_ready;

`ifdef IMEM_MISALIGN_CHK_EN
    assign misalign = |bus.req_pc[1:0];
`else
    assign misalign = 1'b0;
`endif
    assign unused_addr_lo = ^{bus.req_pc[1:0], bus.ld_addr[1:0]};

    // One spare top bit so base+k cannot wrap for PCs near the top of the address space.
    assign base = {1'b0, bus.req_pc[ADDR_W-1:2]};

    for (genvar k = 0; k < FETCH_W; k++) begin : g_slot
        logic [ADDR_W-2:0] idx;
        assign idx                  = base + (ADDR_W-1)'(k);
        assign rd_mask[k]           = ((idx >> IDX_W) == '0) && !misalign;
        assign rd_instr[32*k +: 32] = rd_mask[k] ? mem[idx[IDX_W-1:0]] : 32'h0;
    end

    assign ld_in_range = (bus.ld_addr >> (IDX_W + 2)) == '0;

    // Contents survive reset; only the response register is cleared.
    always_ff @(posedge clk) begin
        if (bus.ld_en && ld_in_range) begin
            mem[bus.ld_addr[IDX_W+1:2]] <= bus.ld_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid_q <= 1'b0;
            resp_pc_q    <= '0;
            resp_instr_q <= '0;
            resp_mask_q  <= '0;
            resp_err_q   <= 1'b0;
        end else if (bus.flush) begin
            resp_valid_q <= 1'b0;
        end else if (accept) begin
            resp_valid_q <= 1'b1;
            resp_pc_q    <= bus.req_pc;
            resp_instr_q <= rd_instr;
            resp_mask_q  <= rd_mask;
            resp_err_q   <= misalign;
        end else if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
        end
    end

    assign bus.req_ready  = req_ready;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_pc    = resp_pc_q;
    assign bus.resp_instr = resp_instr_q;
    assign bus.resp_mask  = resp_mask_q;
    assign bus.resp_err   = resp_err_q;
endmodule

// File: tb/tb_instr_fetch_mem.sv
// Directed plus randomized bench for instr_fetch_mem against a word-array reference model.
module tb_instr_fetch_mem;
    localparam int FW = 2;
    localparam int DW = 16384;
    localparam int AW = 64;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    instr_fetch_mem_if #(.FETCH_W(FW), .ADDR_W(AW)) bus ();

    instr_fetch_mem #(.FETCH_W(FW), .DEPTH_WORDS(DW), .ADDR_W(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0]   mm [int];
    logic          exp_valid;
    logic [AW-1:0] exp_pc;
    logic [63:0]   exp_instr;
    logic [1:0]    exp_mask;
    logic          exp_err;
    logic          exp_ready;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, 128'(bus.resp_valid), 128'(0));
        chk({tag, "_pc"},    128'(bus.resp_pc),    128'(0));
        chk({tag, "_instr"}, 128'(bus.resp_instr), 128'(0));
        chk({tag, "_mask"},  128'(bus.resp_mask),  128'(0));
        chk({tag, "_err"},   128'(bus.resp_err),   128'(0));
    endtask

    function automatic void model_bundle(input logic [63:0] pc, output logic [63:0] ins,
                                         output logic [1:0] msk, output logic err);
        logic [63:0] w;
        w   = pc / 4;
        ins = '0;
        msk = '0;
        err = 1'b0;
`ifdef IMEM_MISALIGN_CHK_EN
        if (pc % 4 != 0) begin
            err = 1'b1;
            return;
        end
`endif
        for (int k = 0; k < FW; k++) begin
            if (w + 64'(k) < 64'(DW)) begin
                msk[k]         = 1'b1;
                ins[32*k +: 32] = mm[int'(w + 64'(k))];
            end
        end
    endfunction

    task automatic set_in(input logic rv, input logic [63:0] pc, input logic rr, input logic fl,
                          input logic le, input logic [63:0] la, input logic [31:0] ld);
        bus.req_valid  = rv;
        bus.req_pc     = pc;
        bus.resp_ready = rr;
        bus.flush      = fl;
        bus.ld_en      = le;
        bus.ld_addr    = la;
        bus.ld_data    = ld;
    endtask

    // One clock: check req_ready mid-cycle, advance the model, check outputs after the edge.
    task automatic cyc();
        exp_ready = !bus.ld_en && !bus.flush && (!exp_valid || bus.resp_ready);
        @(negedge clk);
        chk("req_ready", 128'(bus.req_ready), 128'(exp_ready));
        if (bus.flush) begin
            exp_valid = 1'b0;
        end else if (bus.req_valid && exp_ready) begin
            model_bundle(bus.req_pc, exp_instr, exp_mask, exp_err);
            exp_valid = 1'b1;
            exp_pc    = bus.req_pc;
        end else if (bus.resp_ready) begin
            exp_valid = 1'b0;
        end
        if (bus.ld_en && bus.ld_addr < 64'(4 * DW)) mm[int'(bus.ld_addr / 4)] = bus.ld_data;
        @(posedge clk);
        #1;
        chk("resp_valid", 128'(bus.resp_valid), 128'(exp_valid));
        if (exp_valid) begin
            chk("resp_pc",    128'(bus.resp_pc),    128'(exp_pc));
            chk("resp_instr", 128'(bus.resp_instr), 128'(exp_instr));
            chk("resp_mask",  128'(bus.resp_mask),  128'(exp_mask));
            chk("resp_err",   128'(bus.resp_err),   128'(exp_err));
        end
    endtask

    function automatic logic [63:0] pick_pc();
        logic [63:0] pc;
        case ($urandom_range(0, 4))
            0, 1:    pc = 64'(4 * $urandom_range(0, 62));
            2:       pc = 64'(4 * (DW - 8 + int'($urandom_range(0, 7))));
            3:       pc = 64'(4 * DW) + 64'(4 * $urandom_range(0, 1000));
            default: pc = {1'b1, 31'($urandom), 30'($urandom), 2'b00};
        endcase
        if ($urandom_range(0, 3) == 0) pc[1:0] = 2'($urandom_range(1, 3));
        return pc;
    endfunction

    function automatic logic [63:0] pick_ld_addr();
        if ($urandom_range(0, 5) == 0) return 64'(4 * DW) + 64'(4 * $urandom_range(0, 63));
        if ($urandom_range(0, 1) == 0) return 64'(4 * $urandom_range(0, 63));
        return 64'(4 * (DW - 8 + int'($urandom_range(0, 7))));
    endfunction

    initial begin
        rst_n     = 1'b0;
        exp_valid = 1'b0;
        exp_pc    = '0;
        exp_instr = '0;
        exp_mask  = '0;
        exp_err   = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0);
        #12;
        chk_zero("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Program load with a pending request that must be blocked by ld_en.
        for (int i = 0; i < 64; i++) begin
            logic [31:0] d;
            d = (i == 0) ? 32'h015A04B3 : (i == 1) ? 32'h00148493 : $urandom;
            set_in(1, 0, 1, 0, 1, 64'(4 * i) | ((i > 1) ? 64'(i % 4) : 64'd0), d);
            cyc();
        end
        for (int i = DW - 8; i < DW; i++) begin
            set_in(1, 0, 1, 0, 1, 64'(4 * i), $urandom);
            cyc();
        end
        set_in(0, 0, 1, 0, 1, 64'(4 * DW), 32'hDEADBEEF);
        cyc();

        set_in(1, 0, 1, 0, 0, 0, 0);
        cyc();
        chk("pc0_instr", 128'(bus.resp_instr), 128'(64'h00148493_015A04B3));
        chk("pc0_mask",  128'(bus.resp_mask),  128'(2'b11));

        set_in(1, 64'(4 * DW - 4), 1, 0, 0, 0, 0);
        cyc();
        chk("top_mask",  128'(bus.resp_mask),          128'(2'b01));
        chk("top_slot1", 128'(bus.resp_instr[63:32]),  128'(0));

        // Stall three cycles, overwriting the held word, then release.
        set_in(1, 8, 0, 0, 0, 0, 0);
        cyc();
        set_in(1, 8, 0, 0, 1, 64'(4 * DW - 4), 32'h12345678);
        cyc();
        set_in(1, 8, 0, 0, 0, 0, 0);
        cyc();
        chk("hold_mask", 128'(bus.resp_mask), 128'(2'b01));
        set_in(1, 8, 1, 0, 0, 0, 0);
        cyc();

        set_in(1, 16, 0, 1, 0, 0, 0);
        cyc();
        set_in(0, 16, 1, 0, 0, 0, 0);
        cyc();

        set_in(1, 2, 1, 0, 0, 0, 0);
        cyc();
`ifdef IMEM_MISALIGN_CHK_EN
        chk("mis_err",  128'(bus.resp_err),  128'(1));
        chk("mis_mask", 128'(bus.resp_mask), 128'(0));
`else
        chk("mis_err",   128'(bus.resp_err),   128'(0));
        chk("mis_instr", 128'(bus.resp_instr), 128'(64'h00148493_015A04B3));
`endif

        // Reset pulled while a request is pending and a bundle is held.
        set_in(1, 4, 1, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_zero("rst_async");
        exp_valid = 1'b0;
        @(posedge clk);
        #1;
        chk_zero("rst_hold");
        rst_n = 1'b1;
        set_in(1, 0, 1, 0, 0, 0, 0);
        cyc();
        chk("post_rst_valid", 128'(bus.resp_valid), 128'(1));

        for (int n = 0; n < 400; n++) begin
            logic le;
            le = ($urandom_range(0, 7) == 0);
            set_in(1'($urandom_range(0, 1)), pick_pc(), ($urandom_range(0, 3) != 0),
                   ($urandom_range(0, 9) == 0), le, pick_ld_addr(), $urandom);
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
